// File: rtl/inst_queue_pkg.sv
// Shared instruction-queue types and default sizing.
package Public_Info;

  localparam int PC_W         = 32;
  localparam int IQ_DEPTH     = 8;
  localparam int IQ_IN_LANES  = 2;
  localparam int IQ_OUT_LANES = 2;

  // One fetched instruction slot as carried through the front end.
  typedef struct packed {
    logic [PC_W-1:0] PC;
  } PC_set;

endpackage

// File: rtl/inst_queue_ptr.sv
// Head/tail/count bookkeeping for inst_queue: push gating, pop clamping, wrap.
module inst_queue_ptr
  import Public_Info::*;
#(
  parameter  int DEPTH     = IQ_DEPTH,
  parameter  int IN_LANES  = IQ_IN_LANES,
  parameter  int OUT_LANES = IQ_OUT_LANES,
  localparam int PW        = $clog2(DEPTH),
  localparam int CW        = $clog2(DEPTH + 1),
  localparam int IW        = $clog2(IN_LANES + 1),
  localparam int OW        = $clog2(OUT_LANES + 1)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          flush,
  input  logic [IW-1:0] push_cnt,
  input  logic [OW-1:0] pop_req,
  output logic [PW-1:0] head,
  output logic [PW-1:0] tail,
  output logic [CW-1:0] count,
  output logic          ready
);

  logic [CW-1:0] pop_amt;
  logic [CW-1:0] push_amt;
  logic [CW-1:0] free_slots;

  // Ready only when a full-width push fits; pops never exceed what is held.
  always_comb begin
    free_slots = CW'(DEPTH) - count;
    ready      = (free_slots >= CW'(IN_LANES));
    push_amt   = ready ? CW'(push_cnt) : '0;
    pop_amt    = (CW'(pop_req) > count) ? count : CW'(pop_req);
  end

  // Pointer/count state; flush and reset both collapse the queue to empty.
  // DEPTH is a power of two, so pointer wrap is plain truncation.
  always_ff @(posedge clk) begin
    if (!rstn || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PW'(pop_amt);
      tail  <= tail + PW'(push_amt);
      count <= count + push_amt - pop_amt;
    end
  end

endmodule

// File: rtl/inst_queue.sv
// Multi-lane in-order instruction queue: IN_LANES push, OUT_LANES peek/pop.
module inst_queue
  import Public_Info::*;
#(
  parameter  int DEPTH     = IQ_DEPTH,
  parameter  int IN_LANES  = IQ_IN_LANES,
  parameter  int OUT_LANES = IQ_OUT_LANES,
  localparam int PW        = $clog2(DEPTH),
  localparam int CW        = $clog2(DEPTH + 1),
  localparam int IW        = $clog2(IN_LANES + 1),
  localparam int OW        = $clog2(OUT_LANES + 1)
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        flush,
  input  logic [IN_LANES-1:0]         i_valid,
  input  PC_set [IN_LANES-1:0]        i_data,
  output logic                        o_ready,
  output logic [OUT_LANES-1:0]        o_valid,
  output PC_set [OUT_LANES-1:0]       o_data,
  input  logic [OW-1:0]               i_pop_cnt,
  output logic [CW-1:0]               o_count
);

  PC_set         mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  logic [IW-1:0] push_cnt;
  logic          push_en;

  // Lanes arrive contiguous from lane 0, so the popcount is the push amount.
  always_comb begin
    push_cnt = '0;
    for (int k = 0; k < IN_LANES; k++) push_cnt = push_cnt + IW'(i_valid[k]);
  end

  assign push_en = o_ready & ~flush;

  inst_queue_ptr #(
    .DEPTH    (DEPTH),
    .IN_LANES (IN_LANES),
    .OUT_LANES(OUT_LANES)
  ) u_ptr (
    .clk     (clk),
    .rstn    (rstn),
    .flush   (flush),
    .push_cnt(push_cnt),
    .pop_req (i_pop_cnt),
    .head    (head),
    .tail    (tail),
    .count   (count),
    .ready   (o_ready)
  );

  // Entry storage: lane k lands at tail+k; reset scrubs every slot to zero.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push_en) begin
      for (int k = 0; k < IN_LANES; k++)
        if (i_valid[k]) mem[tail + PW'(k)] <= i_data[k];
    end
  end

  // Output lane mux: lane k shows the k-th oldest entry straight from storage.
  for (genvar k = 0; k < OUT_LANES; k++) begin : g_out
    logic [PW-1:0] rd_idx;
    assign rd_idx     = head + PW'(k);
    assign o_data[k]  = mem[rd_idx];
    assign o_valid[k] = (count > CW'(k));
  end

  assign o_count = count;

endmodule

// File: tb/tb_inst_queue.sv
module tb_inst_queue;
  import Public_Info::*;

  logic         clk = 1'b0;
  logic         rstn;
  logic         flush;
  logic [1:0]   i_valid;
  PC_set [1:0]  i_data;
  logic         o_ready;
  logic [1:0]   o_valid;
  PC_set [1:0]  o_data;
  logic [1:0]   i_pop_cnt;
  logic [3:0]   o_count;

  int n_vec = 0;
  int n_bad = 0;
  int pn, qn;
  localparam logic [31:0] B = 32'h2000_0000;

  always #5 clk = ~clk;

  inst_queue #(.DEPTH(8), .IN_LANES(2), .OUT_LANES(2)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .flush    (flush),
    .i_valid  (i_valid),
    .i_data   (i_data),
    .o_ready  (o_ready),
    .o_valid  (o_valid),
    .o_data   (o_data),
    .i_pop_cnt(i_pop_cnt),
    .o_count  (o_count)
  );

  // Producer must keep valid lanes contiguous from lane 0.
  always @(posedge clk)
    if (rstn && o_ready) assert (i_valid != 2'b10) else $error("non-contiguous i_valid");

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic drv(input logic r, input logic f, input logic [1:0] v,
                     input logic [31:0] p0, input logic [31:0] p1, input logic [1:0] pop);
    rstn = r; flush = f; i_valid = v;
    i_data[0].PC = p0; i_data[1].PC = p1; i_pop_cnt = pop;
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  initial begin
    drv(0, 0, 2'b00, 0, 0, 0);
    tick; tick;
    chk("rst_valid", o_valid, 2'b00);
    chk("rst_ready", o_ready, 1'b1);
    chk("rst_count", o_count, 4'd0);
    chk("rst_d0", o_data[0].PC, 32'h0);
    chk("rst_d1", o_data[1].PC, 32'h0);

    // fill, 2 per cycle, no pops
    drv(1, 0, 2'b11, 32'h100, 32'h104, 0);
    #1 chk("nobypass", o_valid, 2'b00);
    tick;
    chk("fill1_cnt", o_count, 4'd2);
    chk("fill1_vld", o_valid, 2'b11);
    drv(1, 0, 2'b11, 32'h108, 32'h10c, 0); tick;
    chk("fill2_cnt", o_count, 4'd4);
    drv(1, 0, 2'b11, 32'h110, 32'h114, 0); tick;
    chk("fill3_cnt", o_count, 4'd6);
    chk("fill3_rdy", o_ready, 1'b1);
    drv(1, 0, 2'b11, 32'h118, 32'h11c, 0); tick;
    chk("fill4_cnt", o_count, 4'd8);
    chk("fill4_rdy", o_ready, 1'b0);
    drv(1, 0, 2'b11, 32'hdead, 32'hbeef, 0); tick;
    chk("full_cnt", o_count, 4'd8);
    chk("full_d0", o_data[0].PC, 32'h100);
    chk("full_d1", o_data[1].PC, 32'h104);
    drv(1, 0, 2'b00, 0, 0, 2); tick;
    chk("pop2_cnt", o_count, 4'd6);
    chk("pop2_d0", o_data[0].PC, 32'h108);
    chk("pop2_rdy", o_ready, 1'b1);

    // order
    drv(1, 1, 2'b00, 0, 0, 0); tick;
    chk("fl_cnt", o_count, 4'd0);
    drv(1, 0, 2'b11, 32'h1c000000, 32'h1c000004, 0); tick;
    drv(1, 0, 2'b00, 0, 0, 0);
    chk("ord_d0a", o_data[0].PC, 32'h1c000000);
    chk("ord_vld2", o_valid, 2'b11);
    drv(1, 0, 2'b00, 0, 0, 1); tick;
    chk("ord_d0b", o_data[0].PC, 32'h1c000004);
    chk("ord_vld1", o_valid, 2'b01);
    tick;
    chk("ord_vld0", o_valid, 2'b00);
    chk("ord_cnt", o_count, 4'd0);

    // wrap: steady push 2 / pop 2
    drv(1, 0, 2'b11, B, B + 4, 0); tick;
    pn = 2; qn = 0;
    for (int i = 0; i < 20; i++) begin
      chk("wrap_cnt", o_count, 4'd2);
      chk("wrap_d0", o_data[0].PC, B + 32'(4 * qn));
      chk("wrap_d1", o_data[1].PC, B + 32'(4 * (qn + 1)));
      drv(1, 0, 2'b11, B + 32'(4 * pn), B + 32'(4 * (pn + 1)), 2); tick;
      pn += 2; qn += 2;
    end
    chk("wrap_end_cnt", o_count, 4'd2);
    chk("wrap_end_d0", o_data[0].PC, B + 32'(4 * qn));

    // over-pop
    drv(1, 0, 2'b00, 0, 0, 1); tick; qn++;
    chk("op_cnt1", o_count, 4'd1);
    chk("op_vld1", o_valid, 2'b01);
    chk("op_d0", o_data[0].PC, B + 32'(4 * qn));
    drv(1, 0, 2'b00, 0, 0, 2); tick;
    chk("op_cnt0", o_count, 4'd0);
    chk("op_vld0", o_valid, 2'b00);
    drv(1, 0, 2'b11, 32'h3000, 32'h3004, 0); tick;
    chk("op_post_cnt", o_count, 4'd2);
    chk("op_post_d0", o_data[0].PC, 32'h3000);
    chk("op_post_d1", o_data[1].PC, 32'h3004);

    // flush with push and pop in the same cycle
    drv(1, 1, 2'b00, 0, 0, 0); tick;
    drv(1, 0, 2'b11, 32'h50, 32'h54, 0); tick;
    drv(1, 0, 2'b11, 32'h58, 32'h5c, 0); tick;
    drv(1, 0, 2'b01, 32'h60, 32'h0, 0); tick;
    chk("fp_cnt5", o_count, 4'd5);
    drv(1, 1, 2'b11, 32'h70, 32'h74, 1); tick;
    chk("fp_cnt", o_count, 4'd0);
    chk("fp_vld", o_valid, 2'b00);
    chk("fp_rdy", o_ready, 1'b1);
    drv(1, 0, 2'b01, 32'h4000, 32'h0, 0); tick;
    chk("fp_post_cnt", o_count, 4'd1);
    chk("fp_post_d0", o_data[0].PC, 32'h4000);

    // reset mid-operation
    drv(1, 0, 2'b11, 32'h80, 32'h84, 0); tick;
    drv(1, 0, 2'b11, 32'h88, 32'h8c, 0); tick;
    drv(1, 0, 2'b11, 32'h90, 32'h94, 0); tick;
    chk("rm_cnt7", o_count, 4'd7);
    drv(0, 0, 2'b11, 32'ha0, 32'ha4, 2); tick;
    chk("rm_cnt", o_count, 4'd0);
    chk("rm_vld", o_valid, 2'b00);
    chk("rm_rdy", o_ready, 1'b1);
    chk("rm_d0", o_data[0].PC, 32'h0);
    chk("rm_d1", o_data[1].PC, 32'h0);
    drv(1, 0, 2'b00, 0, 0, 0); tick;
    chk("rm_after_cnt", o_count, 4'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
